// File: rtl/ram_lsu_bridge_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ram_lsu_bridge_if: LSU request/response and RAM port bundle            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface ram_lsu_bridge_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  data_req_i;
    logic                  data_gnt_o;
    logic [31:0]           data_addr_i;
    logic                  data_we_i;
    logic [1:0]            data_type_i;
    logic                  data_sign_ext_i;
    logic [31:0]           data_wdata_i;
    logic                  data_rvalid_o;
    logic [31:0]           data_rdata_o;
    logic                  data_err_o;
    logic                  ram_en_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic                  ram_we_o;
    logic [3:0]            ram_be_o;
    logic [31:0]           ram_wdata_o;
    logic [31:0]           ram_rdata_i;

    // LSU and RAM model side
    modport master (
        output data_req_i, data_addr_i, data_we_i, data_type_i, data_sign_ext_i,
        output data_wdata_i, ram_rdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
    );

    // Bridge side
    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_type_i, data_sign_ext_i,
        input  data_wdata_i, ram_rdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/ram_lsu_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ram_lsu_bridge: LSU req/gnt/rvalid to word RAM port with byte enables. |
// | RAM_BRIDGE_MISALIGN_EN splits word-crossing accesses in two.           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ram_lsu_bridge #(
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    ram_lsu_bridge_if.slave bus
);
    logic [1:0]            w_off;
    logic [2:0]            w_size;
    logic [3:0]            w_mask;
    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_cross;
    logic                  w_range_err;
    logic                  w_err;
    logic                  w_idle;
    logic                  w_gnt;
    logic                  w_acc;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_lo;
    logic [31:0]           w_sh;
    logic [31:0]           w_ext;

    logic                  r_rvalid;
    logic                  r_err;
    logic                  r_load;
    logic [1:0]            r_off;
    logic [1:0]            r_type;
    logic                  r_sign;

    assign w_off       = bus.data_addr_i[1:0];
    assign w_word      = bus.data_addr_i[ADDR_WIDTH+1:2];
    assign w_range_err = |bus.data_addr_i[31:ADDR_WIDTH+2];

    always_comb begin
        w_size = 3'd4;
        w_mask = 4'b1111;
        case (bus.data_type_i)
            2'b00:   begin w_size = 3'd1; w_mask = 4'b0001; end
            2'b01:   begin w_size = 3'd2; w_mask = 4'b0011; end
            default: ;
        endcase
    end

    assign w_cross = ({1'b0, w_off} + w_size) > 3'd4;

`ifdef RAM_BRIDGE_MISALIGN_EN
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SECOND = 1'b1
    } state_t;

    state_t                r_state;
    logic [7:0]            w_be8;
    logic [63:0]           w_wd64;
    logic [ADDR_WIDTH-1:0] r_sec_addr;
    logic                  r_sec_we;
    logic [3:0]            r_sec_be;
    logic [31:0]           r_sec_wdata;
    logic                  r_cross;
    logic [31:0]           r_first;

    assign w_be8   = {4'b0000, w_mask} << w_off;
    assign w_wd64  = {32'd0, bus.data_wdata_i} << {w_off, 3'b000};
    assign w_be    = w_be8[3:0];
    assign w_wdata = w_wd64[31:0];
    assign w_idle  = (r_state == S_IDLE);
    // The last word has no successor: crossing out of it must not wrap to word 0.
    assign w_err   = (bus.data_type_i == 2'b11) | w_range_err | (w_cross & (&w_word));
    assign w_lo    = r_cross ? r_first : bus.ram_rdata_i;
`else
    assign w_be    = w_mask << w_off;
    assign w_wdata = bus.data_wdata_i << {w_off, 3'b000};
    assign w_idle  = 1'b1;
    assign w_err   = (bus.data_type_i == 2'b11) | w_range_err | w_cross;
    assign w_lo    = bus.ram_rdata_i;
`endif

    assign w_gnt          = rst_ni & bus.data_req_i & w_idle;
    assign w_acc          = w_gnt & ~w_err;
    assign bus.data_gnt_o = w_gnt;

    always_comb begin
        bus.ram_en_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_we_o    = 1'b0;
        bus.ram_be_o    = 4'b0000;
        bus.ram_wdata_o = 32'd0;
`ifdef RAM_BRIDGE_MISALIGN_EN
        if (rst_ni && (r_state == S_SECOND)) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_addr_o  = r_sec_addr;
            bus.ram_we_o    = r_sec_we;
            bus.ram_be_o    = r_sec_be;
            bus.ram_wdata_o = r_sec_wdata;
        end else
`endif
        if (w_acc) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_addr_o  = w_word;
            bus.ram_we_o    = bus.data_we_i;
            bus.ram_be_o    = w_be;
            bus.ram_wdata_o = w_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_load      <= 1'b0;
            r_off       <= 2'd0;
            r_type      <= 2'd0;
            r_sign      <= 1'b0;
`ifdef RAM_BRIDGE_MISALIGN_EN
            r_state     <= S_IDLE;
            r_cross     <= 1'b0;
            r_first     <= 32'd0;
            r_sec_addr  <= '0;
            r_sec_we    <= 1'b0;
            r_sec_be    <= 4'b0000;
            r_sec_wdata <= 32'd0;
`endif
        end else begin
            r_rvalid <= 1'b0;
`ifdef RAM_BRIDGE_MISALIGN_EN
            if (r_state == S_SECOND) begin
                r_first  <= bus.ram_rdata_i;
                r_rvalid <= 1'b1;
                r_state  <= S_IDLE;
            end else
`endif
            if (w_gnt) begin
                r_off  <= w_off;
                r_type <= bus.data_type_i;
                r_sign <= bus.data_sign_ext_i;
                r_err  <= w_err;
                r_load <= ~bus.data_we_i & ~w_err;
`ifdef RAM_BRIDGE_MISALIGN_EN
                r_cross <= w_cross & ~w_err;
                if (w_cross && !w_err) begin
                    r_state     <= S_SECOND;
                    r_sec_addr  <= w_word + ADDR_WIDTH'(1);
                    r_sec_we    <= bus.data_we_i;
                    r_sec_be    <= w_be8[7:4];
                    r_sec_wdata <= w_wd64[63:32];
                end else begin
                    r_rvalid <= 1'b1;
                end
`else
                r_rvalid <= 1'b1;
`endif
            end
        end
    end

    // Load data is aligned from {second word, first word}; RAM data arrives with rvalid.
    always_comb begin
        w_sh = w_lo;
        case (r_off)
            2'd1:    w_sh = {bus.ram_rdata_i[7:0],  w_lo[31:8]};
            2'd2:    w_sh = {bus.ram_rdata_i[15:0], w_lo[31:16]};
            2'd3:    w_sh = {bus.ram_rdata_i[23:0], w_lo[31:24]};
            default: ;
        endcase
        w_ext = w_sh;
        case (r_type)
            2'b00:   w_ext = {{24{r_sign & w_sh[7]}},  w_sh[7:0]};
            2'b01:   w_ext = {{16{r_sign & w_sh[15]}}, w_sh[15:0]};
            default: ;
        endcase
    end

    assign bus.data_rvalid_o = r_rvalid;
    assign bus.data_err_o    = r_rvalid & r_err;
    assign bus.data_rdata_o  = (r_rvalid & r_load) ? w_ext : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ram_lsu_bridge.sv
`default_nettype none
// tb_ram_lsu_bridge: directed and random LSU traffic against a byte-level memory model.
module tb_ram_lsu_bridge;
    localparam int AW = 8;
    localparam int NW = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    logic preload;
    always #5 clk = ~clk;

    ram_lsu_bridge_if #(.ADDR_WIDTH(AW)) bus ();
    ram_lsu_bridge #(.ADDR_WIDTH(AW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    logic [31:0] ram [NW];
    logic [31:0] pre [NW];
    logic [7:0]  gm  [4*NW];
    int total = 0;
    int bad   = 0;
    logic [31:0] g_rdata;
    logic        g_err;
    logic [31:0] g_a1_addr, g_a2_addr, g_a1_wd, g_a2_wd;
    logic [3:0]  g_a1_be, g_a2_be;

    // RAM port: one-cycle read latency, byte-enabled writes
    always @(posedge clk) begin
        if (preload) begin
            for (int w = 0; w < NW; w++) ram[w] <= pre[w];
            bus.ram_rdata_i <= 32'd0;
        end else if (bus.ram_en_o) begin
            bus.ram_rdata_i <= ram[bus.ram_addr_o];
            if (bus.ram_we_o)
                for (int j = 0; j < 4; j++)
                    if (bus.ram_be_o[j]) ram[bus.ram_addr_o][8*j +: 8] <= bus.ram_wdata_o[8*j +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_size(input logic [1:0] t);
        return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_cross(input logic [31:0] a, input logic [1:0] t);
        return ((a % 4) + m_size(t)) > 4;
    endfunction

    function automatic logic m_err(input logic [31:0] a, input logic [1:0] t);
        if (t == 2'd3) return 1'b1;
        if (a >= 32'(4*NW)) return 1'b1;
        if (longint'(a) + longint'(m_size(t)) > longint'(4*NW)) return 1'b1;
`ifdef RAM_BRIDGE_MISALIGN_EN
        return 1'b0;
`else
        return m_cross(a, t);
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] t, input logic s);
        logic [31:0] v;
        int unsigned n;
        n = m_size(t);
        v = 32'd0;
        for (int i = 0; i < int'(n); i++) v[8*i +: 8] = gm[a + i];
        if (s && v[8*n-1])
            for (int i = int'(n); i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] t, input logic [31:0] wd);
        for (int i = 0; i < int'(m_size(t)); i++) gm[a + i] = wd[8*i +: 8];
    endtask

    function automatic logic [3:0] m_be(input int unsigned w, input logic [31:0] a, input logic [1:0] t);
        logic [3:0] be;
        longint b;
        for (int j = 0; j < 4; j++) begin
            b = longint'(4*w + j);
            be[j] = (b >= longint'(a)) && (b < longint'(a) + longint'(m_size(t)));
        end
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input int unsigned w, input logic [31:0] a, input logic [1:0] t,
                                         input logic [31:0] wd);
        logic [31:0] v;
        logic [3:0]  be;
        int unsigned k;
        v  = 32'd0;
        be = m_be(w, a, t);
        for (int j = 0; j < 4; j++)
            if (be[j]) begin
                k = 4*w + j - a;
                v[8*j +: 8] = wd[8*k +: 8];
            end
        return v;
    endfunction

    task automatic chk_acc(input string tag, input int unsigned w, input logic [31:0] a,
                           input logic [1:0] t, input logic we, input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] lm;
        be = m_be(w, a, t);
        for (int j = 0; j < 4; j++) lm[8*j +: 8] = {8{be[j]}};
        chk({tag, "_en"},   32'(bus.ram_en_o), 32'd1);
        chk({tag, "_addr"}, 32'(bus.ram_addr_o), w);
        chk({tag, "_we"},   32'(bus.ram_we_o), 32'(we));
        chk({tag, "_be"},   32'(bus.ram_be_o), 32'(be));
        if (we) chk({tag, "_wdata"}, bus.ram_wdata_o & lm, m_wd(w, a, t, wd) & lm);
    endtask

    // Called at a falling edge; returns at a falling edge after the response.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [1:0] t,
                          input logic s, input logic [31:0] wd);
        logic        e, sp;
        logic [31:0] exp_rd;
        int unsigned word;
        e      = m_err(a, t);
        sp     = !e && m_cross(a, t);
        word   = a / 4;
        exp_rd = (!e && !w) ? m_load(a, t, s) : 32'd0;
        bus.data_req_i      = 1'b1;
        bus.data_addr_i     = a;
        bus.data_we_i       = w;
        bus.data_type_i     = t;
        bus.data_sign_ext_i = s;
        bus.data_wdata_i    = wd;
        #1;
        chk("gnt", 32'(bus.data_gnt_o), 32'd1);
        g_a1_addr = 32'(bus.ram_addr_o);
        g_a1_be   = bus.ram_be_o;
        g_a1_wd   = bus.ram_wdata_o;
        if (e) chk("err_no_en", 32'(bus.ram_en_o), 32'd0);
        else   chk_acc("acc1", word, a, t, w, wd);
        @(posedge clk); #1;
        if (sp) begin
            chk("gnt_second", 32'(bus.data_gnt_o), 32'd0);
            chk("rvalid_early", 32'(bus.data_rvalid_o), 32'd0);
            g_a2_addr = 32'(bus.ram_addr_o);
            g_a2_be   = bus.ram_be_o;
            g_a2_wd   = bus.ram_wdata_o;
            chk_acc("acc2", word + 1, a, t, w, wd);
            @(posedge clk); #1;
        end
        bus.data_req_i = 1'b0;
        #1;
        chk("rvalid", 32'(bus.data_rvalid_o), 32'd1);
        chk("err", 32'(bus.data_err_o), 32'(e));
        chk("rdata", bus.data_rdata_o, exp_rd);
        g_rdata = bus.data_rdata_o;
        g_err   = bus.data_err_o;
        if (w && !e) m_store(a, t, wd);
        @(posedge clk); #1;
        chk("rvalid_pulse", 32'(bus.data_rvalid_o), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, exp_a, exp_b, wv;
        logic [1:0]  t;
        bus.data_req_i      = 1'b0;
        bus.data_addr_i     = 32'd0;
        bus.data_we_i       = 1'b0;
        bus.data_type_i     = 2'd0;
        bus.data_sign_ext_i = 1'b0;
        bus.data_wdata_i    = 32'd0;
        rst_n   = 1'b0;
        preload = 1'b1;
        for (int w = 0; w < NW; w++) begin
            pre[w] = $urandom;
            for (int j = 0; j < 4; j++) gm[4*w + j] = pre[w][8*j +: 8];
        end
        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        chk("rst_rvalid", 32'(bus.data_rvalid_o), 32'd0);
        chk("rst_err",    32'(bus.data_err_o), 32'd0);
        chk("rst_rdata",  bus.data_rdata_o, 32'd0);
        chk("rst_en",     32'(bus.ram_en_o), 32'd0);
        chk("rst_we",     32'(bus.ram_we_o), 32'd0);
        chk("rst_be",     32'(bus.ram_be_o), 32'd0);
        chk("rst_addr",   32'(bus.ram_addr_o), 32'd0);
        chk("rst_wdata",  bus.ram_wdata_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
        chk("tp_st_be", 32'(g_a1_be), 32'hF);
        chk("tp_st_addr", g_a1_addr, 32'd4);
        do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'd0);
        chk("tp_ld_word", g_rdata, 32'hDEADBEEF);

        do_req(32'h10, 1'b1, 2'd2, 1'b0, 32'h80FF7F01);
        do_req(32'h11, 1'b0, 2'd0, 1'b1, 32'd0);
        chk("tp_b11_s", g_rdata, 32'h0000007F);
        do_req(32'h13, 1'b0, 2'd0, 1'b1, 32'd0);
        chk("tp_b13_s", g_rdata, 32'hFFFFFF80);
        do_req(32'h12, 1'b0, 2'd0, 1'b0, 32'd0);
        chk("tp_b12_u", g_rdata, 32'h000000FF);

        do_req(32'h0C, 1'b1, 2'd2, 1'b0, 32'hAABBCCDD);
        do_req(32'h10, 1'b1, 2'd2, 1'b0, 32'h11223344);
        do_req(32'h0E, 1'b0, 2'd2, 1'b0, 32'd0);
`ifdef RAM_BRIDGE_MISALIGN_EN
        chk("tp_mis_rdata", g_rdata, 32'h3344AABB);
        chk("tp_mis_a1", g_a1_addr, 32'd3);
        chk("tp_mis_a2", g_a2_addr, 32'd4);
`else
        chk("tp_mis_err", 32'(g_err), 32'd1);
`endif
        do_req(32'h07, 1'b1, 2'd1, 1'b0, 32'h0000BEEF);
`ifdef RAM_BRIDGE_MISALIGN_EN
        chk("tp_hs_a1", g_a1_addr, 32'd1);
        chk("tp_hs_be1", 32'(g_a1_be), 32'h8);
        chk("tp_hs_d1", 32'(g_a1_wd[31:24]), 32'hEF);
        chk("tp_hs_a2", g_a2_addr, 32'd2);
        chk("tp_hs_be2", 32'(g_a2_be), 32'h1);
        chk("tp_hs_d2", 32'(g_a2_wd[7:0]), 32'hBE);
`else
        chk("tp_hs_err", 32'(g_err), 32'd1);
`endif
        do_req(32'h400, 1'b0, 2'd0, 1'b0, 32'd0);
        chk("tp_oor_err", 32'(g_err), 32'd1);
        chk("tp_oor_rdata", g_rdata, 32'd0);
        do_req(32'h3FD, 1'b1, 2'd2, 1'b0, 32'h12345678);
        chk("tp_last_err", 32'(g_err), 32'd1);
        chk("tp_last_w255", ram[NW-1], pre[NW-1]);
        chk("tp_last_w0", ram[0], pre[0]);
        do_req(32'h20, 1'b0, 2'd3, 1'b0, 32'd0);
        chk("tp_type_err", 32'(g_err), 32'd1);

        // Back-to-back aligned loads: response N with grant N+1
        exp_a = m_load(32'h10, 2'd2, 1'b0);
        exp_b = m_load(32'h12, 2'd1, 1'b1);
        bus.data_req_i = 1'b1; bus.data_we_i = 1'b0;
        bus.data_addr_i = 32'h10; bus.data_type_i = 2'd2; bus.data_sign_ext_i = 1'b0;
        #1 chk("b2b_gnt0", 32'(bus.data_gnt_o), 32'd1);
        @(posedge clk); #1;
        bus.data_addr_i = 32'h12; bus.data_type_i = 2'd1; bus.data_sign_ext_i = 1'b1;
        #1;
        chk("b2b_gnt1", 32'(bus.data_gnt_o), 32'd1);
        chk("b2b_rv0", 32'(bus.data_rvalid_o), 32'd1);
        chk("b2b_rd0", bus.data_rdata_o, exp_a);
        @(posedge clk); #1;
        bus.data_req_i = 1'b0;
        chk("b2b_rv1", 32'(bus.data_rvalid_o), 32'd1);
        chk("b2b_rd1", bus.data_rdata_o, exp_b);
        @(negedge clk);

`ifdef RAM_BRIDGE_MISALIGN_EN
        // Reset during the second access drops it and its response
        bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_addr_i = 32'h0E;
        bus.data_type_i = 2'd2; bus.data_wdata_i = 32'hCAFEF00D;
        #1 chk("rs_gnt", 32'(bus.data_gnt_o), 32'd1);
        m_store(32'h0E, 2'd1, 32'hCAFEF00D);
        @(posedge clk); #1;
        bus.data_req_i = 1'b0;
        rst_n = 1'b0;
        #1 chk("rs_no_second", 32'(bus.ram_en_o), 32'd0);
        @(posedge clk); #1;
        chk("rs_rvalid", 32'(bus.data_rvalid_o), 32'd0);
        chk("rs_err",    32'(bus.data_err_o), 32'd0);
        chk("rs_rdata",  bus.data_rdata_o, 32'd0);
        chk("rs_en",     32'(bus.ram_en_o), 32'd0);
        chk("rs_be",     32'(bus.ram_be_o), 32'd0);
        chk("rs_wdata",  bus.ram_wdata_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rs_no_resp", 32'(bus.data_rvalid_o), 32'd0);
        chk("rs_w4_kept", ram[4], 32'h11223344);
        @(negedge clk);
`endif

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'(4*NW - 4) + 32'($urandom_range(0, 3));
                default: a = 32'($urandom_range(0, 4*NW - 1));
            endcase
            t  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wv = $urandom;
            do_req(a, 1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)), wv);
        end

        for (int w = 0; w < NW; w++)
            chk("mem_final", ram[w], {gm[4*w+3], gm[4*w+2], gm[4*w+1], gm[4*w]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
